// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP multiplier among NREQ requesters.
// Optional macro FPMUL_ARB_PRIO0_EN gives requester 0 absolute priority over the round-robin.
module fp_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_y,
  output logic [NREQ-1:0]      res_valid,
  output logic [31:0]          res_data,
  output logic                 busy
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_nxt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt;
  logic               ptr_upd;
  logic [MUL_LAT-1:0] tag_v;
  logic [IDW-1:0]     tag_id [MUL_LAT];

  // Search req_valid starting at ptr, wrapping; the first set bit wins.
  always_comb begin
    int sum;
    gnt    = 1'b0;
    gnt_id = '0;
    sum    = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      if (!gnt && req_valid[IDW'(sum)]) begin
        gnt    = 1'b1;
        gnt_id = IDW'(sum);
      end
    end
`ifdef FPMUL_ARB_PRIO0_EN
    if (req_valid[0]) begin
      gnt    = 1'b1;
      gnt_id = '0;
    end
`endif
  end

`ifdef FPMUL_ARB_PRIO0_EN
  assign ptr_upd = gnt && !req_valid[0];
`else
  assign ptr_upd = gnt;
`endif

  assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt && gnt_id == IDW'(i)) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[32*i +: 32];
        mul_b        = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (ptr_upd) begin
      ptr <= ptr_nxt;
    end
  end

  // Tag pipeline: the tail entry is aligned with the multiplier output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= gnt;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= '0;
      if (tag_v[MUL_LAT-1]) begin
        res_valid[tag_id[MUL_LAT-1]] <= 1'b1;
        res_data                     <= mul_y;
      end
    end
  end

  assign busy = (|tag_v) | (|res_valid);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter with a behavioural pipelined FP multiplier.
// Honours FPMUL_ARB_PRIO0_EN when the design is built with it.
module tb_fp_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;
  localparam int LAT     = MUL_LAT + 1;
  localparam int DEPTH   = 1024;

  localparam logic [31:0] OPA [8] = '{32'h40000000, 32'h3FC00000, 32'h40800000, 32'h40400000,
                                      32'hC0000000, 32'h40A00000, 32'h3FA00000, 32'h3F800000};
  localparam logic [31:0] OPB [8] = '{32'h40400000, 32'h40000000, 32'h3F000000, 32'h40400000,
                                      32'h40400000, 32'h40000000, 32'h41000000, 32'h40490FDB};
  localparam logic [31:0] OPP [8] = '{32'h40C00000, 32'h40400000, 32'h40000000, 32'h41100000,
                                      32'hC0C00000, 32'h41200000, 32'h41200000, 32'h40490FDB};

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] a;
    logic [127:0] b;
    logic [3:0]   exp_ready;
    logic [31:0]  ga;
    logic [31:0]  gb;
    logic [31:0]  prod;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  mul_a;
  logic [31:0]  mul_b;
  logic [31:0]  mul_y;
  logic [3:0]   res_valid;
  logic [31:0]  res_data;
  logic         busy;

  int   n_checks;
  int   n_fail;
  int   cyc;
  logic chk_en;
  logic [3:0]  exp_rv   [DEPTH];
  logic [31:0] exp_rd   [DEPTH];
  logic        exp_busy [DEPTH];
  logic [31:0] mpipe    [MUL_LAT];
  vec_t        tbl[$];

  fp_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Truncating single-precision multiply, adequate for normal operands.
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  always @(posedge clk) begin
    mpipe[0] <= fpmul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_y = mpipe[MUL_LAT-1];

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] g, input int opi);
    vec_t v;
    v.valid     = valid;
    v.exp_ready = g;
    v.ga        = OPA[opi % 8];
    v.gb        = OPB[opi % 8];
    v.prod      = OPP[opi % 8];
    v.a         = '0;
    v.b         = '0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        v.a[32*i +: 32] = v.ga;
        v.b[32*i +: 32] = v.gb;
      end else begin
        v.a[32*i +: 32] = 32'h41000000 + 32'(i);
        v.b[32*i +: 32] = 32'h42000000 + 32'(i);
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid = v.valid;
    req_a     = v.a;
    req_b     = v.b;
  endtask

  task automatic clearExp();
    for (int i = 0; i < DEPTH; i++) begin
      exp_rv[i]   = '0;
      exp_rd[i]   = '0;
      exp_busy[i] = 1'b0;
    end
  endtask

  // One cycle: drive, check the combinational grant/operands, schedule the result.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1 applyStimulus(v);
    #1;
    checkOutput("req_ready", 32'(req_ready), 32'(v.exp_ready));
    checkOutput("mul_a", mul_a, (v.exp_ready != 0) ? v.ga : 32'h0);
    checkOutput("mul_b", mul_b, (v.exp_ready != 0) ? v.gb : 32'h0);
    if (v.exp_ready != 0) begin
      exp_rv[cyc + LAT] = v.exp_ready;
      exp_rd[cyc + LAT] = v.prod;
      for (int d = 1; d <= LAT; d++) exp_busy[cyc + d] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("res_valid", 32'(res_valid), 32'(exp_rv[cyc]));
      checkOutput("busy", 32'(busy), 32'(exp_busy[cyc]));
      if (exp_rv[cyc] != 0) checkOutput("res_data", res_data, exp_rd[cyc]);
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    chk_en    = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    clearExp();

    #3;
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_mul_a", mul_a, 32'h0);
    checkOutput("reset_mul_b", mul_b, 32'h0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'h0);
    checkOutput("reset_res_data", res_data, 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Full contention, then single op, pointer wrap/skip and a held request.
    for (int k = 0; k < 8; k++) begin
`ifdef FPMUL_ARB_PRIO0_EN
      tbl.push_back(mk(4'b1111, 4'b0001, k));
`else
      tbl.push_back(mk(4'b1111, 4'(1 << (k % 4)), k));
`endif
    end
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0100, 4'b0100, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b0000, 4'b0000, 0));
    tbl.push_back(mk(4'b0010, 4'b0010, 1));
    tbl.push_back(mk(4'b1010, 4'b1000, 2));
    tbl.push_back(mk(4'b1010, 4'b0010, 3));
    tbl.push_back(mk(4'b1010, 4'b1000, 4));
    tbl.push_back(mk(4'b1010, 4'b0010, 5));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b0010, 4'b0010, 6 + k));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(4'b0000, 4'b0000, 0));

    for (int r = 0; r < tbl.size(); r++) step(tbl[r]);

    // Reset two cycles after the first of three back-to-back issues.
    step(mk(4'b1000, 4'b1000, 7));
    step(mk(4'b0001, 4'b0001, 0));
    @(posedge clk);
    #1 applyStimulus(mk(4'b0010, 4'b0010, 1));
    #1 checkOutput("rst_req_ready", 32'(req_ready), 32'h2);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    clearExp();
    #1;
    checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_res_data", res_data, 32'h0);
    checkOutput("rst_busy_release", 32'(busy), 32'h0);

    // Requesters 0 and 2 continuously valid; pointer must restart at 0.
    for (int k = 0; k < 4; k++) begin
`ifdef FPMUL_ARB_PRIO0_EN
      step(mk(4'b0101, 4'b0001, 2 + k));
`else
      step(mk(4'b0101, (k % 2 == 0) ? 4'b0001 : 4'b0100, 2 + k));
`endif
    end
    step(mk(4'b0100, 4'b0100, 6));
    for (int k = 0; k < 5; k++) step(mk(4'b0000, 4'b0000, 0));

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
